// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven initiator for a combinational alu. Accepts one command at a
// time, drives the alu from a small register bank, writes the result back and returns it.
module alu_sequencer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned NREGS = 4,
   parameter int unsigned CNT_W = 8,
   localparam int unsigned IdxW = $clog2(NREGS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_ld_i,
   input  logic [2:0]       cmd_oc_i,
   input  logic [IdxW-1:0]  cmd_srca_i,
   input  logic [IdxW-1:0]  cmd_srcb_i,
   input  logic [IdxW-1:0]  cmd_dst_i,
   input  logic [WIDTH-1:0] cmd_imm_i,
   output logic [2:0]       alu_oc_o,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   input  logic [WIDTH-1:0] alu_f_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] rsp_data_o,
   output logic [IdxW-1:0]  rsp_dst_o,
   output logic [CNT_W-1:0] op_count_o,
   input  logic [IdxW-1:0]  dbg_sel_i,
   output logic [WIDTH-1:0] dbg_data_o
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] bank_q [NREGS];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [IdxW-1:0]  rsp_dst_q, rsp_dst_d;
   // Command latch; ld/imm are consumed in the accept cycle so they need no storage.
   logic [2:0]       oc_q, oc_d;
   logic [IdxW-1:0]  srca_q, srca_d;
   logic [IdxW-1:0]  srcb_q, srcb_d;
   logic [IdxW-1:0]  dst_q, dst_d;
   // Single bank write port, shared by immediate loads and alu writeback.
   logic             wr_en;
   logic [IdxW-1:0]  wr_addr;
   logic [WIDTH-1:0] wr_data;

   // Next-state, latch capture and bank write selection.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_dst_d  = rsp_dst_q;
      oc_d       = oc_q;
      srca_d     = srca_q;
      srcb_d     = srcb_q;
      dst_d      = dst_q;
      wr_en      = 1'b0;
      wr_addr    = dst_q;
      wr_data    = alu_f_i;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               oc_d   = cmd_oc_i;
               srca_d = cmd_srca_i;
               srcb_d = cmd_srcb_i;
               dst_d  = cmd_dst_i;
               if (cmd_ld_i) begin
                  wr_en      = 1'b1;
                  wr_addr    = cmd_dst_i;
                  wr_data    = cmd_imm_i;
                  rsp_data_d = cmd_imm_i;
                  rsp_dst_d  = cmd_dst_i;
                  state_d    = StResp;
               end else begin
                  state_d = StExec;
               end
            end
         end
         StExec: begin
            wr_en      = 1'b1;
            wr_addr    = dst_q;
            wr_data    = alu_f_i;
            rsp_data_d = alu_f_i;
            rsp_dst_d  = dst_q;
            state_d    = StResp;
         end
         StResp: begin
            if (rsp_ready_i) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, bank and latch registers; synchronous reset aborts any op in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_dst_q  <= '0;
         oc_q       <= '0;
         srca_q     <= '0;
         srcb_q     <= '0;
         dst_q      <= '0;
         for (int i = 0; i < NREGS; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_dst_q  <= rsp_dst_d;
         oc_q       <= oc_d;
         srca_q     <= srca_d;
         srcb_q     <= srcb_d;
         dst_q      <= dst_d;
         if (wr_en) begin
            bank_q[wr_addr] <= wr_data;
         end
      end
   end

   // Outputs; while rst_i is high they present the reset state rather than the stale one.
   always_comb begin
      cmd_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      alu_oc_o    = '0;
      alu_a_o     = '0;
      alu_b_o     = '0;
      rsp_data_o  = '0;
      rsp_dst_o   = '0;
      op_count_o  = '0;
      dbg_data_o  = '0;
      if (!rst_i) begin
         cmd_ready_o = (state_q == StIdle);
         rsp_valid_o = (state_q == StResp);
         rsp_data_o  = rsp_data_q;
         rsp_dst_o   = rsp_dst_q;
         op_count_o  = cnt_q;
         dbg_data_o  = bank_q[dbg_sel_i];
         // The alu only sees operands during the single execute cycle.
         if (state_q == StExec) begin
            alu_oc_o = oc_q;
            alu_a_o  = bank_q[srca_q];
            alu_b_o  = bank_q[srcb_q];
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer with a stub combinational alu and a queue-based scoreboard.
module tb_alu_sequencer;
   localparam int W  = 4;
   localparam int N  = 4;
   localparam int IW = 2;
   localparam int CW = 8;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [IW-1:0] dst;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_ld;
   logic [2:0]    cmd_oc;
   logic [IW-1:0] cmd_srca, cmd_srcb, cmd_dst;
   logic [W-1:0]  cmd_imm;
   logic [2:0]    alu_oc;
   logic [W-1:0]  alu_a, alu_b, alu_f;
   logic          rsp_valid, rsp_ready;
   logic [W-1:0]  rsp_data;
   logic [IW-1:0] rsp_dst;
   logic [CW-1:0] op_count;
   logic [IW-1:0] dbg_sel;
   logic [W-1:0]  dbg_data;

   rsp_t          exp_q[$];
   rsp_t          mon_e;
   logic [W-1:0]  mb[N];
   logic [CW-1:0] exp_cnt = '0;
   int            n_vec = 0;
   int            n_err = 0;
   bit            rand_bp = 0;
   bit            force_ready = 1;

   always #5 clk = ~clk;

   function automatic logic [W-1:0] stub(logic [2:0] oc, logic [W-1:0] a, logic [W-1:0] b);
      case (oc)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b011:  return a - b;
         3'b100:  return a ^ b;
         default: return ~a;
      endcase
   endfunction

   assign alu_f = stub(alu_oc, alu_a, alu_b);

   alu_sequencer #(.WIDTH(W), .NREGS(N), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_ld_i(cmd_ld),
      .cmd_oc_i(cmd_oc), .cmd_srca_i(cmd_srca), .cmd_srcb_i(cmd_srcb),
      .cmd_dst_i(cmd_dst), .cmd_imm_i(cmd_imm),
      .alu_oc_o(alu_oc), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_f_i(alu_f),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_data_o(rsp_data), .rsp_dst_o(rsp_dst), .op_count_o(op_count),
      .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_data)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Consumer readiness: fixed or random, always changed just after the rising edge.
   always @(posedge clk) begin
      #1;
      rsp_ready = rand_bp ? ($urandom_range(0, 3) != 0) : force_ready;
   end

   // Monitor: every response handshake pops one expected entry.
   always @(negedge clk) begin
      if (rst) begin
         exp_cnt = '0;
      end else if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            chk("rsp_dst", 32'(rsp_dst), 32'(mon_e.dst));
            chk("op_count", 32'(op_count), 32'(exp_cnt));
            exp_cnt = exp_cnt + 1'b1;
         end
      end
   end

   task automatic issue(bit ld, logic [2:0] oc, logic [IW-1:0] sa, logic [IW-1:0] sb,
                        logic [IW-1:0] d, logic [W-1:0] imm);
      int t;
      int lat;
      logic [W-1:0] ea, eb, res;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_ld = ld; cmd_oc = oc;
      cmd_srca = sa; cmd_srcb = sb; cmd_dst = d; cmd_imm = imm;
      t = 0;
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         chk("cmd_accept_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      ea  = mb[sa];
      eb  = mb[sb];
      res = ld ? imm : stub(oc, ea, eb);
      mb[d] = res;
      exp_q.push_back(rsp_t'{data: res, dst: d});
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (!ld) begin
         chk("exec_alu_oc", 32'(alu_oc), 32'(oc));
         chk("exec_alu_a", 32'(alu_a), 32'(ea));
         chk("exec_alu_b", 32'(alu_b), 32'(eb));
      end
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 32'(lat), ld ? 32'd1 : 32'd2);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Compares every bank entry against the model; call just after a falling edge.
   task automatic check_bank(string nm);
      for (int i = 0; i < N; i++) begin
         dbg_sel = IW'(i);
         #1;
         chk(nm, 32'(dbg_data), 32'(mb[i]));
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) mb[i] = '0;
   endtask

   initial begin
      clear_model();
      rst = 1'b1; rsp_ready = 1'b1; dbg_sel = '0;
      cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_oc = '0;
      cmd_srca = '0; cmd_srcb = '0; cmd_dst = 2'd1; cmd_imm = 4'h5;

      // Reset held two cycles with a command pending: nothing is accepted.
      repeat (2) begin
         @(negedge clk);
         chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_op_count", 32'(op_count), 32'd0);
         check_bank("rst_bank");
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_bank("post_rst_bank");

      // Immediate load.
      issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd2, 4'hA);
      drain();
      @(negedge clk);
      check_bank("ld_bank");
      chk("ld_op_count", 32'(op_count), 32'd1);

      // Alu op: 3 + 5 into bank3.
      issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 4'h3);
      issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd1, 4'h5);
      issue(1'b0, 3'b010, 2'd0, 2'd1, 2'd3, 4'h0);
      drain();
      @(negedge clk);
      check_bank("alu_bank");
      chk("alu_bank3", 32'(dbg_data), 32'h8);

      // Backpressure with a second command waiting.
      force_ready = 0;
      @(posedge clk);
      #2;
      issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 4'h7);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_dst = 2'd1; cmd_imm = 4'h9;
      repeat (10) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_data", 32'(rsp_data), 32'h7);
         chk("bp_rsp_dst", 32'(rsp_dst), 32'd0);
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("bp_alu_a_idle", 32'(alu_a), 32'd0);
      end
      force_ready = 1;
      issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd1, 4'h9);
      drain();
      @(negedge clk);
      check_bank("bp_bank");
      chk("bp_op_count", 32'(op_count), 32'(exp_cnt));

      // Fully aliased operands: F + F truncates to E.
      issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd1, 4'hF);
      issue(1'b0, 3'b010, 2'd1, 2'd1, 2'd1, 4'h0);
      drain();
      @(negedge clk);
      dbg_sel = 2'd1;
      #1;
      chk("alias_result", 32'(dbg_data), 32'hE);

      // Counter wrap: 256 loads from a fresh reset bring op_count back to 0.
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
      for (int i = 0; i < 256; i++) begin
         issue(1'b1, 3'b000, 2'd0, 2'd0, IW'($urandom_range(0, N - 1)), W'($urandom));
      end
      drain();
      @(negedge clk);
      chk("wrap_op_count", 32'(op_count), 32'd0);
      check_bank("wrap_bank");

      // Reset while executing: no writeback, no response.
      issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 4'h3);
      issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd1, 4'h5);
      drain();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_oc = 3'b010;
      cmd_srca = 2'd0; cmd_srcb = 2'd1; cmd_dst = 2'd2;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("midop_in_exec", 32'(alu_oc), 32'(3'b010));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
      repeat (4) begin
         @(negedge clk);
         chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      check_bank("midop_bank");
      chk("midop_op_count", 32'(op_count), 32'd0);

      // Random commands under random backpressure.
      rand_bp = 1;
      for (int i = 0; i < 200; i++) begin
         issue($urandom_range(0, 2) == 0, 3'($urandom), IW'($urandom), IW'($urandom),
               IW'($urandom), W'($urandom));
      end
      drain();
      rand_bp = 0;
      @(negedge clk);
      check_bank("rand_bank");
      chk("rand_op_count", 32'(op_count), 32'(exp_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
